// File: rtl/pipeline_pkg.sv
// Shared types for the EX/MEM and MEM/WB pipeline registers and the MEM access controller.
package pipeline_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_LOAD = 2'd1,
    WSEL_LUI  = 2'd2
  } wsel_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } memfsm_t;

  typedef struct packed {
    logic [15:0] ireg;
    regbits_t    dest;
    logic        rfwen;
    word_t       aluout;
    word_t       lui32;
    word_t       storedat;
    logic        dren;
    logic        dwen;
    wsel_t       wsel;
    logic        halt;
  } exmem_t;

  typedef struct packed {
    logic [15:0] ireg;
    regbits_t    dest;
    logic        rfwen;
    word_t       aluout;
    word_t       lui32;
    word_t       lddata;
    wsel_t       wsel;
    logic        halt;
  } memwb_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory request controller: holds the request until dhit and keeps
// the load data when the pipeline cannot advance in the hit cycle.
module mem_access_ctrl
  import pipeline_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  acc_i,
  input  logic  dren_i,
  input  logic  dwen_i,
  input  logic  dhit_i,
  input  logic  adv_i,
  input  word_t dmemload_i,
  output logic  dmem_ren_o,
  output logic  dmem_wen_o,
  output logic  mem_stall_o,
  output word_t ld_data_o
);

  memfsm_t state_q, state_d;
  word_t   ldhold_q, ldhold_d;
  logic    done;
  logic    hit;

  assign done = (state_q == M_DONE);
  // A hit counts only while the access is still outstanding.
  assign hit  = acc_i & dhit_i & ~done;

  assign dmem_ren_o  = acc_i & dren_i & ~done;
  assign dmem_wen_o  = acc_i & dwen_i & ~done;
  assign mem_stall_o = acc_i & ~dhit_i & ~done;
  assign ld_data_o   = hit ? dmemload_i : ldhold_q;

  always_comb begin
    state_d  = state_q;
    ldhold_d = ldhold_q;
    if (hit) begin
      ldhold_d = dmemload_i;
    end
    case (state_q)
      M_IDLE: begin
        if (acc_i && !dhit_i) begin
          state_d = M_WAIT;
        end else if (acc_i && dhit_i && !adv_i) begin
          state_d = M_DONE;
        end
      end
      M_WAIT: begin
        if (dhit_i && !adv_i) begin
          state_d = M_DONE;
        end
      end
      M_DONE:  state_d = M_DONE;
      default: state_d = M_IDLE;
    endcase
    if (adv_i) begin
      state_d = M_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= M_IDLE;
      ldhold_q <= '0;
    end else begin
      state_q  <= state_d;
      ldhold_q <= ldhold_d;
    end
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-memory request controller.
module ex_mem_wb_pipe
  import pipeline_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        flush_ex,
  input  logic [15:0] ex_reg,
  input  logic [4:0]  ex_dest,
  input  logic        ex_rfWEN,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_lui32,
  input  logic [31:0] ex_storedat,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic [1:0]  ex_wsel,
  input  logic        ex_halt,
  output logic [15:0] mem_reg,
  output logic [4:0]  mem_dest,
  output logic        mem_rfWEN,
  output logic [31:0] mem_aluout,
  output logic [31:0] mem_lui32,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [15:0] wb_reg,
  output logic [4:0]  wb_dest,
  output logic        wb_rfWEN,
  output logic [31:0] wb_aluout,
  output logic [31:0] wb_lui32,
  output logic [31:0] wb_wdat,
  output logic        mem_stall,
  output logic        halt
);

  exmem_t mem_q, mem_d;
  memwb_t wb_q, wb_d;
  logic   halt_q, halt_d;
  logic   acc;
  logic   adv;
  word_t  ld_data;

  // A bubble is all zeros, so any access flag implies a valid instruction.
  assign acc = mem_q.dren | mem_q.dwen;
  assign adv = ihit & ~mem_stall & ~halt_q;

  mem_access_ctrl u_mem_access_ctrl (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .acc_i       (acc),
    .dren_i      (mem_q.dren),
    .dwen_i      (mem_q.dwen),
    .dhit_i      (dhit),
    .adv_i       (adv),
    .dmemload_i  (dmemload),
    .dmem_ren_o  (dmemREN),
    .dmem_wen_o  (dmemWEN),
    .mem_stall_o (mem_stall),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    mem_d  = mem_q;
    wb_d   = wb_q;
    halt_d = halt_q;
    if (adv) begin
      if (flush_ex) begin
        mem_d = '0;
      end else begin
        mem_d.ireg     = ex_reg;
        mem_d.dest     = ex_dest;
        mem_d.rfwen    = ex_rfWEN & (ex_dest != 5'd0);
        mem_d.aluout   = ex_aluout;
        mem_d.lui32    = ex_lui32;
        mem_d.storedat = ex_storedat;
        mem_d.dren     = ex_dREN;
        mem_d.dwen     = ex_dWEN;
        mem_d.wsel     = wsel_t'(ex_wsel);
        mem_d.halt     = ex_halt;
      end
      wb_d.ireg   = mem_q.ireg;
      wb_d.dest   = mem_q.dest;
      wb_d.rfwen  = mem_q.rfwen;
      wb_d.aluout = mem_q.aluout;
      wb_d.lui32  = mem_q.lui32;
      wb_d.lddata = ld_data;
      wb_d.wsel   = mem_q.wsel;
      wb_d.halt   = mem_q.halt;
      if (mem_q.halt) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem_q  <= '0;
      wb_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      halt_q <= halt_d;
    end
  end

  always_comb begin
    wb_wdat = '0;
    case (wb_q.wsel)
      WSEL_ALU:  wb_wdat = wb_q.aluout;
      WSEL_LOAD: wb_wdat = wb_q.lddata;
      WSEL_LUI:  wb_wdat = wb_q.lui32;
      default:   wb_wdat = '0;
    endcase
  end

  assign mem_reg    = mem_q.ireg;
  assign mem_dest   = mem_q.dest;
  assign mem_rfWEN  = mem_q.rfwen;
  assign mem_aluout = mem_q.aluout;
  assign mem_lui32  = mem_q.lui32;
  assign dmemaddr   = mem_q.aluout;
  assign dmemstore  = mem_q.storedat;
  assign wb_reg     = wb_q.ireg;
  assign wb_dest    = wb_q.dest;
  assign wb_rfWEN   = wb_q.rfwen;
  assign wb_aluout  = wb_q.aluout;
  assign wb_lui32   = wb_q.lui32;
  assign halt       = halt_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed self-checking bench for ex_mem_wb_pipe.
module tb_ex_mem_wb_pipe;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, flush_ex;
  logic [31:0] dmemload;
  logic [15:0] ex_reg;
  logic [4:0]  ex_dest;
  logic        ex_rfWEN, ex_dREN, ex_dWEN, ex_halt;
  logic [31:0] ex_aluout, ex_lui32, ex_storedat;
  logic [1:0]  ex_wsel;
  logic [15:0] mem_reg, wb_reg;
  logic [4:0]  mem_dest, wb_dest;
  logic        mem_rfWEN, wb_rfWEN, dmemREN, dmemWEN, mem_stall, halt;
  logic [31:0] mem_aluout, mem_lui32, dmemaddr, dmemstore, wb_aluout, wb_lui32, wb_wdat;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ex_mem_wb_pipe dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .flush_ex(flush_ex), .ex_reg(ex_reg), .ex_dest(ex_dest), .ex_rfWEN(ex_rfWEN),
    .ex_aluout(ex_aluout), .ex_lui32(ex_lui32), .ex_storedat(ex_storedat),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_wsel(ex_wsel), .ex_halt(ex_halt),
    .mem_reg(mem_reg), .mem_dest(mem_dest), .mem_rfWEN(mem_rfWEN),
    .mem_aluout(mem_aluout), .mem_lui32(mem_lui32), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .wb_reg(wb_reg), .wb_dest(wb_dest), .wb_rfWEN(wb_rfWEN), .wb_aluout(wb_aluout),
    .wb_lui32(wb_lui32), .wb_wdat(wb_wdat), .mem_stall(mem_stall), .halt(halt)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ex_nop();
    flush_ex = 0; ex_reg = '0; ex_dest = '0; ex_rfWEN = 0; ex_aluout = '0;
    ex_lui32 = '0; ex_storedat = '0; ex_dREN = 0; ex_dWEN = 0; ex_wsel = 2'd0;
    ex_halt = 0;
  endtask

  task automatic ex_alu(input logic [4:0] d, input logic [31:0] a);
    ex_nop();
    ex_dest = d; ex_rfWEN = 1; ex_aluout = a; ex_reg = 16'h1234;
  endtask

  task automatic ex_load(input logic [4:0] d, input logic [31:0] addr);
    ex_nop();
    ex_dest = d; ex_rfWEN = 1; ex_aluout = addr; ex_dREN = 1; ex_wsel = 2'd1;
  endtask

  task automatic do_reset();
    nRST = 0; ihit = 0; dhit = 0; dmemload = '0; ex_nop();
    step();
    step();
    nRST = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_reg, mem_dest, mem_rfWEN, mem_aluout, mem_lui32, dmemREN, dmemWEN, dmemaddr,
         dmemstore, wb_reg, wb_dest, wb_rfWEN, wb_aluout, wb_lui32, wb_wdat, mem_stall,
         halt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mem_dest=%0d wb_dest=%0d dmemREN=%b halt=%b, want all 0",
               mem_dest, wb_dest, dmemREN, halt);
    end
  endtask

  task automatic test_alu();
    ihit = 1;
    ex_alu(5'd8, 32'h0000_00FF);
    step();
    ex_nop();
    checks++;
    if (mem_dest !== 5'd8 || mem_rfWEN !== 1'b1 || mem_aluout !== 32'hFF) begin
      errors++;
      $display("FAIL alu_mem: got dest=%0d rfWEN=%b alu=%h, want 8 1 ff",
               mem_dest, mem_rfWEN, mem_aluout);
    end
    step();
    checks++;
    if (wb_wdat !== 32'hFF || wb_dest !== 5'd8 || wb_rfWEN !== 1'b1) begin
      errors++;
      $display("FAIL alu_wb: got wdat=%h dest=%0d rfWEN=%b, want ff 8 1",
               wb_wdat, wb_dest, wb_rfWEN);
    end
  endtask

  task automatic test_load_late();
    int stalls;
    ihit = 1;
    ex_load(5'd9, 32'h0000_0100);
    step();
    ex_alu(5'd10, 32'h0000_000A);
    checks++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h100) begin
      errors++;
      $display("FAIL load_req: got REN=%b addr=%h, want 1 100", dmemREN, dmemaddr);
    end
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_stall === 1'b1) stalls++;
      step();
    end
    checks++;
    if (stalls !== 3 || mem_dest !== 5'd9 || wb_dest !== 5'd0 || dmemREN !== 1'b1) begin
      errors++;
      $display("FAIL load_stall: got stalls=%0d mem_dest=%0d wb_dest=%0d REN=%b, want 3 9 0 1",
               stalls, mem_dest, wb_dest, dmemREN);
    end
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_hit_stall: got %b, want 0", mem_stall);
    end
    step();
    dhit = 0; dmemload = 32'h0;
    ex_nop();
    checks++;
    if (wb_wdat !== 32'hDEAD_BEEF || wb_dest !== 5'd9 || mem_dest !== 5'd10 ||
        dmemREN !== 1'b0) begin
      errors++;
      $display("FAIL load_wb: got wdat=%h wb_dest=%0d mem_dest=%0d REN=%b, want deadbeef 9 10 0",
               wb_wdat, wb_dest, mem_dest, dmemREN);
    end
  endtask

  task automatic test_dhit_no_ihit();
    ihit = 1;
    ex_load(5'd3, 32'h0000_0040);
    step();
    ex_nop();
    ihit = 0; dhit = 1; dmemload = 32'h1234_5678;
    #1;
    checks++;
    if (dmemREN !== 1'b1 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL noihit_hit: got REN=%b stall=%b, want 1 0", dmemREN, mem_stall);
    end
    step();
    dhit = 0; dmemload = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || mem_dest !== 5'd3) begin
      errors++;
      $display("FAIL noihit_done: got REN=%b stall=%b mem_dest=%0d, want 0 0 3",
               dmemREN, mem_stall, mem_dest);
    end
    step();
    ihit = 1;
    step();
    checks++;
    if (wb_wdat !== 32'h1234_5678 || wb_dest !== 5'd3) begin
      errors++;
      $display("FAIL noihit_ldhold: got wdat=%h dest=%0d, want 12345678 3", wb_wdat, wb_dest);
    end
    dmemload = '0;
  endtask

  task automatic test_flush();
    ihit = 1;
    ex_alu(5'd5, 32'h55);
    flush_ex = 1;
    step();
    ex_nop();
    checks++;
    if (mem_rfWEN !== 1'b0 || mem_dest !== 5'd0 || mem_aluout !== 32'h0 || mem_reg !== 16'h0) begin
      errors++;
      $display("FAIL flush_bubble: got rfWEN=%b dest=%0d alu=%h, want 0 0 0",
               mem_rfWEN, mem_dest, mem_aluout);
    end
  endtask

  task automatic test_zero_dest();
    ihit = 1;
    ex_alu(5'd0, 32'h77);
    step();
    ex_nop();
    checks++;
    if (mem_rfWEN !== 1'b0 || mem_aluout !== 32'h77) begin
      errors++;
      $display("FAIL zero_dest: got rfWEN=%b alu=%h, want 0 77", mem_rfWEN, mem_aluout);
    end
  endtask

  task automatic test_back_to_back();
    ihit = 1;
    ex_nop();
    ex_dWEN = 1; ex_aluout = 32'h200; ex_storedat = 32'hCAFE;
    step();
    ex_alu(5'd1, 32'h11);
    dhit = 1;
    #1;
    checks++;
    if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'hCAFE ||
        dmemaddr !== 32'h200 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL store_req: got WEN=%b REN=%b st=%h addr=%h stall=%b, want 1 0 cafe 200 0",
               dmemWEN, dmemREN, dmemstore, dmemaddr, mem_stall);
    end
    step();
    dhit = 0;
    ex_alu(5'd2, 32'h99);
    ex_lui32 = 32'h22; ex_wsel = 2'd2;
    checks++;
    if (dmemWEN !== 1'b0 || wb_rfWEN !== 1'b0 || mem_dest !== 5'd1) begin
      errors++;
      $display("FAIL store_wb: got WEN=%b wb_rfWEN=%b mem_dest=%0d, want 0 0 1",
               dmemWEN, wb_rfWEN, mem_dest);
    end
    step();
    ex_nop();
    checks++;
    if (mem_dest !== 5'd2 || wb_dest !== 5'd1 || wb_wdat !== 32'h11) begin
      errors++;
      $display("FAIL b2b_first: got mem_dest=%0d wb_dest=%0d wdat=%h, want 2 1 11",
               mem_dest, wb_dest, wb_wdat);
    end
    step();
    checks++;
    if (wb_wdat !== 32'h22 || wb_lui32 !== 32'h22 || wb_aluout !== 32'h99) begin
      errors++;
      $display("FAIL b2b_lui: got wdat=%h lui=%h alu=%h, want 22 22 99",
               wb_wdat, wb_lui32, wb_aluout);
    end
  endtask

  task automatic test_halt();
    ihit = 1;
    ex_nop();
    ex_halt = 1;
    step();
    ex_alu(5'd11, 32'hB);
    checks++;
    if (halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: got %b, want 0", halt);
    end
    step();
    ex_alu(5'd12, 32'hC);
    checks++;
    if (halt !== 1'b1 || mem_dest !== 5'd11) begin
      errors++;
      $display("FAIL halt_set: got halt=%b mem_dest=%0d, want 1 11", halt, mem_dest);
    end
    step();
    step();
    checks++;
    if (halt !== 1'b1 || mem_dest !== 5'd11 || wb_dest !== 5'd0) begin
      errors++;
      $display("FAIL halt_block: got halt=%b mem_dest=%0d wb_dest=%0d, want 1 11 0",
               halt, mem_dest, wb_dest);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    ihit = 1;
    ex_alu(5'd4, 32'h4);
    step();
    ex_load(5'd6, 32'h300);
    step();
    step();
    checks++;
    if (mem_stall !== 1'b1 || dmemREN !== 1'b1) begin
      errors++;
      $display("FAIL midload_wait: got stall=%b REN=%b, want 1 1", mem_stall, dmemREN);
    end
    nRST = 0;
    step();
    checks++;
    if (dmemREN !== 1'b0 || mem_dest !== 5'd0 || wb_dest !== 5'd0 || wb_rfWEN !== 1'b0 ||
        mem_aluout !== 32'h0 || halt !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: got REN=%b mem_dest=%0d wb_dest=%0d halt=%b stall=%b, want 0",
               dmemREN, mem_dest, wb_dest, halt, mem_stall);
    end
    nRST = 1;
    ex_nop();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_late();
    test_dhit_no_ihit();
    test_flush();
    test_zero_dest();
    test_back_to_back();
    test_halt();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
